// File: rtl/sensor_timing_ctrl_if.sv
// Configuration port of the frame-timing sequencer: valid/ready geometry word
// plus the one-cycle reject pulse.
interface sensor_timing_ctrl_if #(
  parameter int H_W   = 16,
  parameter int V_W   = 13,
  parameter int FRM_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [H_W-1:0]   cfg_h_total;
  logic [V_W-1:0]   cfg_v_total;
  logic [H_W-1:0]   cfg_h_porch;
  logic [V_W-1:0]   cfg_v_porch;
  logic [FRM_W-1:0] cfg_frames;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_h_total, cfg_v_total, cfg_h_porch, cfg_v_porch, cfg_frames,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h_total, cfg_v_total, cfg_h_porch, cfg_v_porch, cfg_frames,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/sensor_timing_ctrl.sv
// Programmable frame-timing sequencer: owns the pixel/line counters and drives
// HD/VD from a run-time geometry that only changes at frame boundaries.
module sensor_timing_ctrl #(
  parameter int H_W   = 16,
  parameter int V_W   = 13,
  parameter int FRM_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sensor_timing_ctrl_if.slave  cfg,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic [H_W-1:0]       hcnt,
  output logic [V_W-1:0]       vcnt,
  output logic                 hd,
  output logic                 vd,
  output logic                 line_start,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  typedef struct packed {
    logic [H_W-1:0] ht;
    logic [H_W-1:0] hp;
    logic [V_W-1:0] vt;
    logic [V_W-1:0] vp;
  } geom_t;

  state_t           state, state_nxt;
  geom_t            act, act_nxt, shd, shd_nxt, word;
  logic [FRM_W-1:0] frames, frames_nxt, shd_frames, shd_frames_nxt;
  logic [FRM_W-1:0] frm_cnt, frm_cnt_nxt;
  logic             shd_pend, shd_pend_nxt, stop_pend, stop_pend_nxt;
  logic [H_W-1:0]   hcnt_nxt;
  logic [V_W-1:0]   vcnt_nxt;
  logic             hs, word_ok, line_end, boundary, last_frame, run_nxt;
  logic             hd_nxt, vd_nxt, ls_nxt, fd_nxt, err_nxt;

  function automatic logic legal(geom_t g);
    return (g.ht >= H_W'(2)) && (g.vt >= V_W'(1)) && (g.hp < g.ht) && (g.vp < g.vt);
  endfunction

  assign word = '{ht: cfg.cfg_h_total, hp: cfg.cfg_h_porch,
                  vt: cfg.cfg_v_total, vp: cfg.cfg_v_porch};
  assign word_ok       = legal(word);
  assign cfg.cfg_ready = !shd_pend;
  assign hs            = cfg.cfg_valid && !shd_pend;
  assign busy          = (state != IDLE);

  assign line_end   = (hcnt == act.ht - H_W'(1));
  assign boundary   = (state == RUN) && line_end && (vcnt == act.vt - V_W'(1));
  assign last_frame = (frames != '0) && (FRM_W'(frm_cnt + FRM_W'(1)) == frames);

  always_comb begin
    state_nxt      = state;
    act_nxt        = act;
    frames_nxt     = frames;
    shd_nxt        = shd;
    shd_frames_nxt = shd_frames;
    shd_pend_nxt   = shd_pend;
    stop_pend_nxt  = stop_pend;
    frm_cnt_nxt    = frm_cnt;
    hcnt_nxt       = '0;
    vcnt_nxt       = '0;
    err_nxt        = hs && !word_ok;

    // Accepted words go straight to active when idle, else park in the shadow.
    if (hs && word_ok) begin
      if (state == IDLE) begin
        act_nxt    = word;
        frames_nxt = cfg.cfg_frames;
      end else begin
        shd_nxt        = word;
        shd_frames_nxt = cfg.cfg_frames;
        shd_pend_nxt   = 1'b1;
      end
    end
    if (state == IDLE && shd_pend) begin
      act_nxt      = shd;
      frames_nxt   = shd_frames;
      shd_pend_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start && !stop && legal(act)) begin
          state_nxt     = ARM;
          frm_cnt_nxt   = '0;
          stop_pend_nxt = 1'b0;
        end
      end
      ARM: state_nxt = stop ? IDLE : RUN;
      RUN: begin
        if (stop) stop_pend_nxt = 1'b1;
        if (boundary) begin
          frm_cnt_nxt = frm_cnt + FRM_W'(1);
          // Only geometry swaps mid-run; the frame count stays as started.
          if (shd_pend) begin
            act_nxt      = shd;
            shd_pend_nxt = 1'b0;
          end
          if (stop_pend || stop || last_frame) begin
            state_nxt     = IDLE;
            stop_pend_nxt = 1'b0;
          end
        end else if (line_end) begin
          vcnt_nxt = vcnt + V_W'(1);
        end else begin
          hcnt_nxt = hcnt + H_W'(1);
          vcnt_nxt = vcnt;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Strobes are registered from next-cycle counters so they line up with hcnt/vcnt.
    run_nxt = (state_nxt == RUN);
    hd_nxt  = run_nxt && (hcnt_nxt > act_nxt.hp);
    vd_nxt  = run_nxt && (vcnt_nxt > act_nxt.vp);
    ls_nxt  = run_nxt && (hcnt_nxt == '0);
    fd_nxt  = run_nxt && (hcnt_nxt == act_nxt.ht - H_W'(1))
                      && (vcnt_nxt == act_nxt.vt - V_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      act         <= '{ht: H_W'(64), hp: H_W'(6), vt: V_W'(32), vp: '0};
      frames      <= '0;
      shd         <= '0;
      shd_frames  <= '0;
      shd_pend    <= 1'b0;
      stop_pend   <= 1'b0;
      frm_cnt     <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      hd          <= 1'b0;
      vd          <= 1'b0;
      line_start  <= 1'b0;
      frame_done  <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      act         <= act_nxt;
      frames      <= frames_nxt;
      shd         <= shd_nxt;
      shd_frames  <= shd_frames_nxt;
      shd_pend    <= shd_pend_nxt;
      stop_pend   <= stop_pend_nxt;
      frm_cnt     <= frm_cnt_nxt;
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      hd          <= hd_nxt;
      vd          <= vd_nxt;
      line_start  <= ls_nxt;
      frame_done  <= fd_nxt;
      cfg.cfg_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sensor_timing_ctrl.sv
// Directed bench for sensor_timing_ctrl: per-cycle expectations are queued from
// the geometry when a run is launched and popped as the run plays out.
module tb_sensor_timing_ctrl;
  localparam int H_W = 16, V_W = 13, FRM_W = 8;

  typedef struct packed {
    logic           busy, rdy, err, hd, vd, ls, fd;
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
  } obs_t;

  logic clk, rst_n, start, stop;
  logic busy, hd, vd, line_start, frame_done;
  logic [H_W-1:0] hcnt;
  logic [V_W-1:0] vcnt;
  obs_t cur;
  obs_t sb[$];
  int total = 0, bad = 0;

  sensor_timing_ctrl_if #(.H_W(H_W), .V_W(V_W), .FRM_W(FRM_W)) ifc();

  sensor_timing_ctrl #(.H_W(H_W), .V_W(V_W), .FRM_W(FRM_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(ifc), .start(start), .stop(stop),
    .busy(busy), .hcnt(hcnt), .vcnt(vcnt), .hd(hd), .vd(vd),
    .line_start(line_start), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur = {busy, ifc.cfg_ready, ifc.cfg_err, hd, vd, line_start, frame_done, hcnt, vcnt};

  function automatic obs_t mk(logic b, logic r, logic e, logic h_d, logic v_d,
                              logic ls, logic fd, int h, int v);
    obs_t o;
    o.busy = b; o.rdy = r; o.err = e; o.hd = h_d; o.vd = v_d; o.ls = ls; o.fd = fd;
    o.h = H_W'(h); o.v = V_W'(v);
    return o;
  endfunction

  function automatic obs_t idle_exp(logic e);
    return mk(1'b0, 1'b1, e, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endfunction

  function automatic obs_t arm_exp();
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, obs_t o, obs_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (h=%0d v=%0d vs h=%0d v=%0d)",
             tag, o, e, o.h, o.v, e.h, e.v);
    end
  endtask

  // Expected RUN cycles of one frame; cfg_ready low for frame cycles lo..hi.
  task automatic push_frame(int ht, int vt, int hp, int vp, int n, int lo, int hi);
    for (int i = 0; i < n; i++) begin
      int h, v;
      h = i % ht;
      v = (i / ht) % vt;
      sb.push_back(mk(1'b1, !(i >= lo && i <= hi), 1'b0, h > hp, v > vp, h == 0,
                      (h == ht - 1) && (v == vt - 1), h, v));
    end
  endtask

  task automatic cmp_one(string tag);
    obs_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      total--;
      e = sb.pop_front();
      chk(tag, cur, e);
    end
  endtask

  task automatic drain(string name, int n, int stop_at, int cfg_at);
    for (int k = 0; k < n; k++) begin
      cmp_one($sformatf("%s_c%0d", name, k));
      stop = (k == stop_at);
      ifc.cfg_valid = (k == cfg_at);
      tick();
    end
    stop = 1'b0;
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic set_cfg(int ht, int vt, int hp, int vp, int fr);
    ifc.cfg_h_total = H_W'(ht);
    ifc.cfg_v_total = V_W'(vt);
    ifc.cfg_h_porch = H_W'(hp);
    ifc.cfg_v_porch = V_W'(vp);
    ifc.cfg_frames  = FRM_W'(fr);
  endtask

  task automatic load(string name, int ht, int vt, int hp, int vp, int fr, logic e);
    set_cfg(ht, vt, hp, vp, fr);
    ifc.cfg_valid = 1'b1;
    tick();
    ifc.cfg_valid = 1'b0;
    chk({name, "_err"}, cur, idle_exp(e));
    tick();
    chk({name, "_after"}, cur, idle_exp(1'b0));
  endtask

  task automatic go(string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_arm"}, cur, arm_exp());
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    ifc.cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    tick(); tick();
    chk("reset", cur, idle_exp(1'b0));
    rst_n = 1'b1;
    tick();
    chk("post_reset", cur, idle_exp(1'b0));

    // Two frames of 8x4, porch 1/0.
    load("cfg2", 8, 4, 1, 0, 2, 1'b0);
    go("two");
    push_frame(8, 4, 1, 0, 32, -1, -2);
    push_frame(8, 4, 1, 0, 32, -1, -2);
    drain("two", 64, -1, -1);
    chk("two_end", cur, idle_exp(1'b0));

    // Continuous run, graceful stop mid-frame.
    load("cfg0", 8, 4, 1, 0, 0, 1'b0);
    go("stop");
    push_frame(8, 4, 1, 0, 32, -1, -2);
    drain("stop", 32, 10, -1);
    chk("stop_end", cur, idle_exp(1'b0));

    // Geometry offered mid-run applies from the next frame.
    go("upd");
    set_cfg(6, 3, 0, 1, 0);
    push_frame(8, 4, 1, 0, 32, 6, 31);
    push_frame(6, 3, 0, 1, 18, -1, -2);
    drain("upd", 50, 35, 5);
    chk("upd_end", cur, idle_exp(1'b0));

    // Illegal words are consumed, flagged, and leave 6x3 active.
    load("bad_ht", 1, 4, 0, 0, 1, 1'b1);
    load("bad_hp", 8, 4, 8, 0, 1, 1'b1);
    go("keep");
    push_frame(6, 3, 0, 1, 18, -1, -2);
    drain("keep", 18, 0, -1);
    chk("keep_end", cur, idle_exp(1'b0));

    // Stop seen in ARM aborts the run.
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b1;
    chk("abort_arm", cur, arm_exp());
    tick();
    stop = 1'b0;
    chk("abort_idle", cur, idle_exp(1'b0));

    // Reset mid-frame restores outputs and default geometry.
    load("cfg_r", 8, 4, 1, 0, 0, 1'b0);
    go("rst");
    push_frame(8, 4, 1, 0, 21, -1, -2);
    drain("rst", 20, -1, -1);
    cmp_one("rst_c20");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_val", cur, idle_exp(1'b0));
    go("dflt");
    push_frame(64, 32, 6, 0, 2048, -1, -2);
    drain("dflt", 2048, 0, -1);
    chk("dflt_end", cur, idle_exp(1'b0));

    // Start held across a whole run: no restart until IDLE is reached.
    load("cfg_h", 4, 2, 1, 0, 2, 1'b0);
    start = 1'b1;
    tick();
    chk("hold_arm", cur, arm_exp());
    tick();
    push_frame(4, 2, 1, 0, 8, -1, -2);
    push_frame(4, 2, 1, 0, 8, -1, -2);
    drain("hold", 16, -1, -1);
    chk("hold_gap", cur, idle_exp(1'b0));
    tick();
    chk("hold_rearm", cur, arm_exp());
    start = 1'b0;
    tick();
    push_frame(4, 2, 1, 0, 8, -1, -2);
    push_frame(4, 2, 1, 0, 8, -1, -2);
    drain("hold2", 16, -1, -1);
    chk("hold2_end", cur, idle_exp(1'b0));

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sensor_timing_ctrl.md
# sensor_timing_ctrl

Programmable frame-timing sequencer for the sensor drive path. It owns the horizontal/vertical pixel counters and generates the HD/VD drive strobes from a run-time configuration, replacing fixed compile-time geometry. It accepts geometry through a valid/ready config port, starts and stops on command, and runs either N frames or continuously. Geometry changes made while running take effect only at a frame boundary.

## Interface
- H_W, 16, width of horizontal count and geometry fields
- V_W, 13, width of vertical count and geometry fields
- FRM_W, 8, width of the frame-count field

Ports:
- clk  in  1  pixel clock (CLI domain); all logic on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- cfg_valid  in  1  config word present
- cfg_ready  out  1  config can be accepted this cycle
- cfg_h_total  in  H_W  pixels per line
- cfg_v_total  in  V_W  lines per frame
- cfg_h_porch  in  H_W  horizontal back porch
- cfg_v_porch  in  V_W  vertical back porch
- cfg_frames  in  FRM_W  frames per run; 0 means continuous
- cfg_err  out  1  one-cycle pulse when an offered config is rejected
- start  in  1  begin a run (level-sampled, acted on in IDLE only)
- stop  in  1  request graceful stop (level-sampled)
- busy  out  1  state is ARM or RUN
- hcnt  out  H_W  current pixel index
- vcnt  out  V_W  current line index
- hd  out  1  horizontal drive: hcnt > h_porch, RUN only
- vd  out  1  vertical drive: vcnt > v_porch, RUN only
- line_start  out  1  pulse when hcnt == 0 in RUN
- frame_done  out  1  pulse on last pixel of each frame

## Operation
- Registers: active config (h_total, v_total, h_porch, v_porch, frames), shadow config plus shadow_pend flag, frame counter, stop_pend flag.
- Legal config: h_total >= 2, v_total >= 1, h_porch < h_total, v_porch < v_total. An illegal word is still handshaken (consumed), is not loaded, and pulses cfg_err the following cycle.
- cfg_ready = !shadow_pend. In IDLE, a legal handshaked word loads the active config directly. In ARM/RUN it loads the shadow and sets shadow_pend.
- States: IDLE -> ARM on start (stop low, active config legal); ARM -> RUN after exactly one cycle; RUN -> IDLE at a frame boundary when stop_pend is set or the frame counter reaches frames (frames != 0); ARM -> IDLE if stop is seen in ARM.
- Frame boundary: RUN with hcnt == h_total-1 and vcnt == v_total-1. At that cycle frame_done = 1, the frame counter increments, and a pending shadow's geometry moves to active (shadow_pend clears). The frames field is taken only on start.
- Counters: hcnt wraps at h_total-1 to 0 and advances vcnt. vcnt wraps at v_total-1 to 0. All compares use full-width unsigned values, with no overflow past total-1.
- start while busy is ignored. Stop while RUN sets stop_pend, and the current frame always completes. When stop and count-completion coincide, the result is a single transition to IDLE.
- On leaving RUN, hcnt/vcnt return to 0 and stop_pend clears. A pending shadow remains pending and loads into active in IDLE on the next cycle.

## Timing
- Reset values: busy 0, hd 0, vd 0, hcnt 0, vcnt 0, line_start 0, frame_done 0, cfg_err 0, cfg_ready 1. The active config resets to h_total 64, v_total 32, h_porch 6, v_porch 0, frames 0. shadow_pend, stop_pend and the frame counter reset to 0.
- Reset is synchronous and overrides everything, including mid-frame: all outputs reach their reset values at the first clk edge with rst_n low.
- start sampled at edge t: busy = 1 from t+1 (ARM), RUN from t+2 with hcnt = 0, vcnt = 0, line_start = 1.
- hd, vd, line_start and frame_done are flop outputs aligned with hcnt/vcnt in the same cycle, with no extra latency. All are 0 outside RUN.
- Run length for N frames: N·h_total·v_total RUN cycles. busy drops in the cycle after the final frame_done.
- New geometry applies starting at the hcnt = 0 cycle following the boundary.

## Test plan
- Config 8/4/1/0, frames = 2, start -> busy after 1 cycle, 64 RUN cycles, frame_done at RUN cycles 31 and 63, then IDLE. hd is 0 for hcnt 0–1 and 1 for hcnt 2–7. vd is 0 for vcnt 0 and 1 for vcnt 1–3.
- frames = 0, stop asserted at RUN cycle 10 of an 8×4 frame -> frame completes, frame_done at cycle 31, busy 0 at cycle 32, hcnt/vcnt back to 0.
- In RUN, offer 6/3/0/1 at cycle 5 -> cfg_ready drops next cycle. Geometry unchanged until cycle 31. The next frame is 18 cycles, with vd low for vcnt 0–1. cfg_ready returns to 1 after the boundary.
- Offer h_total = 1, then h_porch = 8 with h_total = 8 -> each word consumed and followed by a cfg_err pulse; the active config is unchanged.
- rst_n low at RUN cycle 20 for one cycle -> next edge: all outputs at reset values, config back to 64/32/6/0. A subsequent start runs a 64×32 frame.
- start held high through a whole 2-frame run -> one ARM, no restart while busy. After IDLE, a new ARM begins on the next sampled start.
